// File: rtl/pe_seq_ctrl.sv
// Sequencer for one dot-product PE: walks the neuron/weight buffers chunk by chunk,
// drives the PE vld/ctl pipeline and collects one indexed result per output.
//
// state   | meaning
// S_IDLE  | waiting for start; cfg is latched on the start edge
// S_RUN   | issuing one buffer read per non-stalled cycle
// S_DRAIN | all reads issued, waiting for the remaining PE results
// S_DONE  | one-cycle done pulse, then back to idle
module pe_seq_ctrl #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 8,
  parameter int CNT_W  = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_vec_len,
  input  logic [CNT_W-1:0]  cfg_num_out,
  input  logic [ADDR_W-1:0] cfg_nbuf_base,
  input  logic [ADDR_W-1:0] cfg_wbuf_base,
  input  logic              stall,
  output logic              busy,
  output logic              done,
  output logic              nbuf_rd_en,
  output logic [ADDR_W-1:0] nbuf_addr,
  output logic              wbuf_rd_en,
  output logic [ADDR_W-1:0] wbuf_addr,
  output logic              pe_vld_i,
  output logic [1:0]        pe_ctl,
  input  logic              pe_vld_o,
  input  logic [31:0]       pe_result,
  output logic              res_vld,
  output logic [31:0]       res_data,
  output logic [CNT_W-1:0]  res_idx
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state;
  logic [LEN_W-1:0]  len_q;
  logic [CNT_W-1:0]  num_q;
  logic [ADDR_W-1:0] nbase_q;
  logic [LEN_W-1:0]  k;
  logic [CNT_W-1:0]  j;
  logic              issue;
  logic              k_first;
  logic              k_last;
  logic              j_last;
  logic              res_last;
  logic [2:0]        pipe [RD_LAT];

  assign issue      = (state == S_RUN) && !stall;
  assign k_first    = (k == '0);
  assign k_last     = (k == len_q - LEN_W'(1));
  assign j_last     = (j == num_q - CNT_W'(1));
  assign res_last   = (res_idx == num_q - CNT_W'(1));
  assign nbuf_rd_en = issue;
  assign wbuf_rd_en = issue;
  assign busy       = (state == S_RUN) || (state == S_DRAIN);
  assign done       = (state == S_DONE);

  // Weight address is a running counter: wbuf_base + j*L + k without a multiplier.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      len_q     <= '0;
      num_q     <= '0;
      nbase_q   <= '0;
      k         <= '0;
      j         <= '0;
      nbuf_addr <= '0;
      wbuf_addr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            len_q     <= cfg_vec_len;
            num_q     <= cfg_num_out;
            nbase_q   <= cfg_nbuf_base;
            k         <= '0;
            j         <= '0;
            nbuf_addr <= cfg_nbuf_base;
            wbuf_addr <= cfg_wbuf_base;
            state     <= (cfg_vec_len == '0 || cfg_num_out == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (!stall) begin
            wbuf_addr <= wbuf_addr + ADDR_W'(1);
            if (k_last) begin
              k         <= '0;
              nbuf_addr <= nbase_q;
              j         <= j + CNT_W'(1);
              if (j_last) state <= S_DRAIN;
            end else begin
              k         <= k + LEN_W'(1);
              nbuf_addr <= nbuf_addr + ADDR_W'(1);
            end
          end
        end
        S_DRAIN: begin
          if (res_vld && res_last) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Control travels alongside the read so it lines up with the returning operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= {issue, issue & k_last, issue & k_first};
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign pe_vld_i = pipe[RD_LAT-1][2];
  assign pe_ctl   = pipe[RD_LAT-1][1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      res_vld  <= 1'b0;
      res_data <= '0;
      res_idx  <= '0;
    end else begin
      res_vld  <= pe_vld_o;
      res_data <= pe_result;
      if (state == S_IDLE && start) begin
        res_idx <= '0;
      end else if (res_vld) begin
        res_idx <= (state == S_DRAIN && res_last) ? '0 : res_idx + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Bench for pe_seq_ctrl: buffer and PE models around the DUT, expected per-cycle schedule
// derived from the job parameters and the stall pattern.
module tb_pe_seq_ctrl;
  localparam int RD_LAT = 1;
  localparam int MAXC   = 512;

  logic        clk = 1'b0;
  logic        rst, start, stall;
  logic [7:0]  cfg_vec_len, cfg_num_out;
  logic [9:0]  cfg_nbuf_base, cfg_wbuf_base;
  logic        busy, done, nbuf_rd_en, wbuf_rd_en, pe_vld_i, pe_vld_o, res_vld;
  logic [9:0]  nbuf_addr, wbuf_addr;
  logic [1:0]  pe_ctl;
  logic [31:0] pe_result, res_data;
  logic [7:0]  res_idx;

  int errors = 0;
  int checks = 0;

  logic [31:0] nmem [1024];
  logic [31:0] wmem [1024];
  logic [31:0] nq, wq, acc;

  bit          stall_pat [MAXC];
  bit          e_rd [MAXC];
  logic [9:0]  e_na [MAXC];
  logic [9:0]  e_wa [MAXC];
  bit          e_vld [MAXC];
  logic [1:0]  e_ctl [MAXC];
  bit          e_res [MAXC];
  logic [31:0] e_data [MAXC];
  logic [7:0]  e_idx [MAXC];

  pe_seq_ctrl #(.ADDR_W(10), .LEN_W(8), .CNT_W(8), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_vec_len(cfg_vec_len), .cfg_num_out(cfg_num_out),
    .cfg_nbuf_base(cfg_nbuf_base), .cfg_wbuf_base(cfg_wbuf_base),
    .stall(stall), .busy(busy), .done(done),
    .nbuf_rd_en(nbuf_rd_en), .nbuf_addr(nbuf_addr),
    .wbuf_rd_en(wbuf_rd_en), .wbuf_addr(wbuf_addr),
    .pe_vld_i(pe_vld_i), .pe_ctl(pe_ctl),
    .pe_vld_o(pe_vld_o), .pe_result(pe_result),
    .res_vld(res_vld), .res_data(res_data), .res_idx(res_idx)
  );

  always #5 clk = ~clk;

  // Buffers with one cycle of read latency.
  always @(posedge clk) begin
    if (nbuf_rd_en) nq <= nmem[nbuf_addr];
    if (wbuf_rd_en) wq <= wmem[wbuf_addr];
  end

  // PE: ctl[0] restarts the accumulation, ctl[1] alone produces vld_o.
  always @(posedge clk) begin
    if (rst) begin
      pe_vld_o  <= 1'b0;
      pe_result <= '0;
      acc       <= '0;
    end else begin
      pe_vld_o <= pe_ctl[1];
      if (pe_vld_i) begin
        acc <= (pe_ctl[0] ? 32'd0 : acc) + nq * wq;
        if (pe_ctl[1]) pe_result <= (pe_ctl[0] ? 32'd0 : acc) + nq * wq;
      end
    end
  end

  task automatic run_job(input string name, input int L, input int N,
                         input logic [9:0] nb, input logic [9:0] wb,
                         input int s_lo, input int s_hi, input bit rnd, input bit inject);
    int c, last, done_cyc;
    logic [31:0] sum;
    for (int i = 0; i < MAXC; i++) begin
      stall_pat[i] = ((i >= s_lo) && (i <= s_hi)) || (rnd && ($urandom_range(0, 3) == 0));
      e_rd[i] = 0; e_vld[i] = 0; e_res[i] = 0;
      e_na[i] = '0; e_wa[i] = '0; e_ctl[i] = '0; e_data[i] = '0; e_idx[i] = '0;
    end
    c = 1;
    last = 0;
    for (int jj = 0; jj < N; jj++) begin
      sum = '0;
      for (int kk = 0; kk < L; kk++) begin
        while (c < MAXC - 8 && stall_pat[c]) c++;
        e_rd[c] = 1;
        e_na[c] = 10'(nb + kk);
        e_wa[c] = 10'(wb + jj * L + kk);
        sum += nmem[e_na[c]] * wmem[e_wa[c]];
        e_vld[c + RD_LAT] = 1;
        e_ctl[c + RD_LAT] = {kk == L - 1, kk == 0};
        if (kk == L - 1) begin
          e_res[c + RD_LAT + 2]  = 1;
          e_data[c + RD_LAT + 2] = sum;
          e_idx[c + RD_LAT + 2]  = 8'(jj);
        end
        last = c;
        c++;
      end
    end
    done_cyc = (L == 0 || N == 0) ? 1 : last + RD_LAT + 3;

    @(negedge clk);
    cfg_vec_len = 8'(L); cfg_num_out = 8'(N);
    cfg_nbuf_base = nb; cfg_wbuf_base = wb;
    stall = 1'b0; start = 1'b1;
    @(posedge clk);
    for (int cy = 1; cy <= done_cyc + 2; cy++) begin
      #1;
      start = inject && (cy == 3 || cy == done_cyc);
      stall = stall_pat[cy];
      @(negedge clk);
      checks++;
      if (nbuf_rd_en !== e_rd[cy] || wbuf_rd_en !== e_rd[cy]) begin
        errors++;
        $display("FAIL %s rd_en c=%0d got n=%0b w=%0b exp %0b", name, cy, nbuf_rd_en, wbuf_rd_en, e_rd[cy]);
      end
      if (e_rd[cy]) begin
        checks++;
        if (nbuf_addr !== e_na[cy] || wbuf_addr !== e_wa[cy]) begin
          errors++;
          $display("FAIL %s addr c=%0d got n=%h w=%h exp n=%h w=%h", name, cy, nbuf_addr, wbuf_addr, e_na[cy], e_wa[cy]);
        end
      end
      checks++;
      if (pe_vld_i !== e_vld[cy] || pe_ctl !== e_ctl[cy]) begin
        errors++;
        $display("FAIL %s pe c=%0d got vld=%0b ctl=%b exp vld=%0b ctl=%b", name, cy, pe_vld_i, pe_ctl, e_vld[cy], e_ctl[cy]);
      end
      checks++;
      if (res_vld !== e_res[cy]) begin
        errors++;
        $display("FAIL %s res_vld c=%0d got %0b exp %0b", name, cy, res_vld, e_res[cy]);
      end
      if (e_res[cy]) begin
        checks++;
        if (res_data !== e_data[cy] || res_idx !== e_idx[cy]) begin
          errors++;
          $display("FAIL %s result c=%0d got %h idx %0d exp %h idx %0d", name, cy, res_data, res_idx, e_data[cy], e_idx[cy]);
        end
      end
      checks++;
      if (done !== (cy == done_cyc) || busy !== (cy < done_cyc && done_cyc > 1)) begin
        errors++;
        $display("FAIL %s done/busy c=%0d got done=%0b busy=%0b exp done_cycle=%0d", name, cy, done, busy, done_cyc);
      end
      @(posedge clk);
    end
    #1;
    start = 1'b0;
    stall = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stall = 1'b0;
    cfg_vec_len = '0; cfg_num_out = '0; cfg_nbuf_base = '0; cfg_wbuf_base = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, nbuf_rd_en, wbuf_rd_en, pe_vld_i, pe_ctl, res_vld} !== '0 ||
        nbuf_addr !== '0 || wbuf_addr !== '0 || res_data !== '0 || res_idx !== '0) begin
      errors++;
      $display("FAIL reset outputs got busy=%0b done=%0b rd=%0b vld=%0b res_vld=%0b exp all 0", busy, done, nbuf_rd_en, pe_vld_i, res_vld);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    run_job("basic", 4, 2, 10'h010, 10'h100, -1, -1, 0, 0);
  endtask

  task automatic test_single_chunk();
    run_job("single", 1, 3, 10'h020, 10'h200, -1, -1, 0, 0);
  endtask

  task automatic test_stall();
    run_job("stall", 3, 2, 10'h030, 10'h040, 2, 4, 0, 0);
  endtask

  task automatic test_zero_len();
    run_job("zero_len", 0, 3, 10'h005, 10'h006, -1, -1, 0, 0);
    run_job("zero_num", 2, 0, 10'h005, 10'h006, -1, -1, 0, 0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    cfg_vec_len = 8'd3; cfg_num_out = 8'd2;
    cfg_nbuf_base = 10'h050; cfg_wbuf_base = 10'h060;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid busy before reset got %0b exp 1", busy);
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, nbuf_rd_en, wbuf_rd_en, pe_vld_i, pe_ctl, res_vld} !== '0 ||
        nbuf_addr !== '0 || wbuf_addr !== '0 || res_data !== '0 || res_idx !== '0) begin
      errors++;
      $display("FAIL reset_mid outputs got busy=%0b done=%0b rd=%0b vld=%0b res_vld=%0b exp all 0", busy, done, nbuf_rd_en, pe_vld_i, res_vld);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || res_vld !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid aborted job got done=%0b busy=%0b res_vld=%0b exp 0", done, busy, res_vld);
      end
    end
    run_job("after_reset", 2, 1, 10'h070, 10'h080, -1, -1, 0, 0);
  endtask

  task automatic test_start_ignored();
    run_job("start_ignored", 3, 2, 10'h0A0, 10'h0B0, -1, -1, 0, 1);
  endtask

  task automatic test_addr_wrap();
    run_job("wrap", 4, 2, 10'h3FD, 10'h3FE, -1, -1, 0, 0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      run_job("random", int'($urandom_range(1, 6)), int'($urandom_range(1, 5)),
              10'($urandom), 10'($urandom), -1, -1, 1, 0);
    end
  endtask

  task automatic test_back_to_back();
    run_job("b2b_a", 2, 3, 10'h111, 10'h222, -1, -1, 0, 0);
    run_job("b2b_b", 5, 1, 10'h333, 10'h044, -1, -1, 1, 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      nmem[i] = $urandom;
      wmem[i] = $urandom;
    end
    test_reset();
    test_basic();
    test_single_chunk();
    test_stall();
    test_zero_len();
    test_reset_mid();
    test_start_ignored();
    test_addr_wrap();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
